// File: rtl/spi_pin_port_ctrl.sv
// Purpose: SPI master-to-pad adapter; registers pad drives, synchronizes DQ inputs
//          and sequences DQ bus direction through a guarded turnaround FSM.
// Latency: pad outputs 1 cycle; spi_dq_i SYNC_STAGES cycles (+1 in loopback);
//          pins_dq_oe rises TURN_CYC+1 cycles after the first output-enable request.
// Backpressure: none; a pin-level pass-through that accepts new values every cycle.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   spi_sck, spi_dq_o, spi_dq_oe,   master-side serial clock, data, per-line OE,
//   spi_cs, spi_dq_i                active-low chip selects, synchronized read data
//   cfg_loopback                    feed driven DQ values back into the synchronizer
//   pins_sck_*, pins_dq_*,          pad controls (value, output enable, input enable,
//   pins_cs_*                       pull-up enable) and pad input values
//   dir_state                       direction FSM state (0 IN, 1 TURN, 2 OUT)

module spi_pin_port_ctrl #(
  parameter int DQ_W        = 4,
  parameter int CS_W        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYC    = 1
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            spi_sck,
  input  logic [DQ_W-1:0] spi_dq_o,
  input  logic [DQ_W-1:0] spi_dq_oe,
  output logic [DQ_W-1:0] spi_dq_i,
  input  logic [CS_W-1:0] spi_cs,

  input  logic            cfg_loopback,

  output logic            pins_sck_oval,
  output logic            pins_sck_oe,
  input  logic [DQ_W-1:0] pins_dq_ival,
  output logic [DQ_W-1:0] pins_dq_oval,
  output logic [DQ_W-1:0] pins_dq_oe,
  output logic [DQ_W-1:0] pins_dq_ie,
  output logic [DQ_W-1:0] pins_dq_pue,
  output logic [CS_W-1:0] pins_cs_oval,
  output logic [CS_W-1:0] pins_cs_oe,

  output logic [1:0]      dir_state
);

  typedef enum logic [1:0] {
    ST_IN   = 2'd0,
    ST_TURN = 2'd1,
    ST_OUT  = 2'd2,
    ST_BAD  = 2'd3
  } dir_st_e;

  // Counter preload; TURN is skipped entirely when TURN_CYC is zero.
  localparam logic [3:0] TURN_LOAD = (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;

  // ---------------------------------------------------------------------------
  // Output pad value registers
  // ---------------------------------------------------------------------------
  logic            sck_q;
  logic [DQ_W-1:0] dq_oval_q;
  logic [CS_W-1:0] cs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q     <= 1'b0;
      dq_oval_q <= '0;
      cs_q      <= '1;  // chip selects idle deasserted
    end else begin
      sck_q     <= spi_sck;
      dq_oval_q <= spi_dq_o;
      cs_q      <= spi_cs;
    end
  end

  assign pins_sck_oval = sck_q;
  assign pins_dq_oval  = dq_oval_q;
  assign pins_cs_oval  = cs_q;
  assign pins_sck_oe   = 1'b1;
  assign pins_cs_oe    = '1;
  assign pins_dq_pue   = '1;

  // ---------------------------------------------------------------------------
  // DQ input synchronizer. In loopback the chain samples the registered pad
  // drive value, so loopback data arrives one cycle later than pad data.
  // ---------------------------------------------------------------------------
  logic [DQ_W-1:0] sync_d;
  logic [DQ_W-1:0] sync_q [SYNC_STAGES];

  assign sync_d = cfg_loopback ? dq_oval_q : pins_dq_ival;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= sync_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign spi_dq_i = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Bus direction FSM. Pad oe/ie are registered alongside the state so that
  // oe can only be non-zero in the same cycle the state register reads OUT.
  // ---------------------------------------------------------------------------
  logic            dir_req;
  dir_st_e         state_q;
  logic [3:0]      cnt_q;
  logic [DQ_W-1:0] dq_oe_q;
  logic [DQ_W-1:0] dq_ie_q;

  assign dir_req = |spi_dq_oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IN;
      cnt_q   <= 4'd0;
      dq_oe_q <= '0;
      dq_ie_q <= '1;
    end else begin
      case (state_q)
        ST_IN: begin
          if (dir_req && (TURN_CYC == 0)) begin
            state_q <= ST_OUT;
            dq_oe_q <= spi_dq_oe;
            dq_ie_q <= ~spi_dq_oe;
          end else if (dir_req) begin
            // Guard window: neither side drives or listens.
            state_q <= ST_TURN;
            cnt_q   <= TURN_LOAD;
            dq_oe_q <= '0;
            dq_ie_q <= '0;
          end else begin
            dq_oe_q <= '0;
            dq_ie_q <= '1;
          end
        end

        ST_TURN: begin
          if (!dir_req) begin
            // Request withdrawn during the guard: abort back to input.
            state_q <= ST_IN;
            cnt_q   <= 4'd0;
            dq_oe_q <= '0;
            dq_ie_q <= '1;
          end else if (cnt_q == 4'd0) begin
            state_q <= ST_OUT;
            dq_oe_q <= spi_dq_oe;
            dq_ie_q <= ~spi_dq_oe;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        ST_OUT: begin
          if (!dir_req) begin
            state_q <= ST_IN;
            dq_oe_q <= '0;
            dq_ie_q <= '1;
          end else begin
            // Per-line enable changes track with one cycle of latency.
            dq_oe_q <= spi_dq_oe;
            dq_ie_q <= ~spi_dq_oe;
          end
        end

        default: begin
          state_q <= ST_IN;
          cnt_q   <= 4'd0;
          dq_oe_q <= '0;
          dq_ie_q <= '1;
        end
      endcase
    end
  end

  assign pins_dq_oe = dq_oe_q;
  assign pins_dq_ie = dq_ie_q;
  assign dir_state  = state_q;

endmodule

// File: tb/tb_spi_pin_port_ctrl.sv
// Purpose: self-checking bench for spi_pin_port_ctrl (TURN_CYC=3 and TURN_CYC=0 instances).
// Latency: checks sampled at the falling edge, inputs driven at the falling edge.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_spi_pin_port_ctrl;
  localparam int DQ_W = 4;
  localparam int CS_W = 4;
  localparam int SYNC = 2;
  localparam int TURN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            spi_sck;
  logic [DQ_W-1:0] spi_dq_o, spi_dq_oe, pins_dq_ival;
  logic [CS_W-1:0] spi_cs;
  logic            cfg_loopback;

  // TURN_CYC=3 instance outputs
  logic [DQ_W-1:0] spi_dq_i, pins_dq_oval, pins_dq_oe, pins_dq_ie, pins_dq_pue;
  logic [CS_W-1:0] pins_cs_oval, pins_cs_oe;
  logic            pins_sck_oval, pins_sck_oe;
  logic [1:0]      dir_state;
  // TURN_CYC=0 instance outputs
  logic [DQ_W-1:0] spi_dq_i_z, pins_dq_oval_z, pins_dq_oe_z, pins_dq_ie_z, pins_dq_pue_z;
  logic [CS_W-1:0] pins_cs_oval_z, pins_cs_oe_z;
  logic            pins_sck_oval_z, pins_sck_oe_z;
  logic [1:0]      dir_state_z;

  spi_pin_port_ctrl #(.DQ_W(DQ_W), .CS_W(CS_W), .SYNC_STAGES(SYNC), .TURN_CYC(TURN)) u_dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_dq_o(spi_dq_o), .spi_dq_oe(spi_dq_oe),
    .spi_dq_i(spi_dq_i), .spi_cs(spi_cs), .cfg_loopback(cfg_loopback),
    .pins_sck_oval(pins_sck_oval), .pins_sck_oe(pins_sck_oe), .pins_dq_ival(pins_dq_ival),
    .pins_dq_oval(pins_dq_oval), .pins_dq_oe(pins_dq_oe), .pins_dq_ie(pins_dq_ie),
    .pins_dq_pue(pins_dq_pue), .pins_cs_oval(pins_cs_oval), .pins_cs_oe(pins_cs_oe),
    .dir_state(dir_state)
  );

  spi_pin_port_ctrl #(.DQ_W(DQ_W), .CS_W(CS_W), .SYNC_STAGES(SYNC), .TURN_CYC(0)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_dq_o(spi_dq_o), .spi_dq_oe(spi_dq_oe),
    .spi_dq_i(spi_dq_i_z), .spi_cs(spi_cs), .cfg_loopback(cfg_loopback),
    .pins_sck_oval(pins_sck_oval_z), .pins_sck_oe(pins_sck_oe_z), .pins_dq_ival(pins_dq_ival),
    .pins_dq_oval(pins_dq_oval_z), .pins_dq_oe(pins_dq_oe_z), .pins_dq_ie(pins_dq_ie_z),
    .pins_dq_pue(pins_dq_pue_z), .pins_cs_oval(pins_cs_oval_z), .pins_cs_oe(pins_cs_oe_z),
    .dir_state(dir_state_z)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------------------------------------------------------------------
  // Reference model: direction depends only on how many consecutive sampled
  // edges have seen a non-zero output-enable request; the input path is a
  // plain delay line of the selected source.
  // ---------------------------------------------------------------------------
  int              m_run;
  logic [DQ_W-1:0] m_oe_s, m_dq_oval, m_din;
  logic [CS_W-1:0] m_cs;
  logic            m_sck;
  logic [DQ_W-1:0] m_sh [SYNC];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_oe_s = '0; m_dq_oval = '0; m_cs = '1; m_sck = 1'b0;
      for (int i = 0; i < SYNC; i++) m_sh[i] = '0;
    end else begin
      m_din = cfg_loopback ? m_dq_oval : pins_dq_ival;
      for (int i = SYNC-1; i > 0; i--) m_sh[i] = m_sh[i-1];
      m_sh[0] = m_din;
      m_run = (spi_dq_oe != 0) ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
      m_oe_s = spi_dq_oe; m_dq_oval = spi_dq_o; m_cs = spi_cs; m_sck = spi_sck;
    end
  end

  function automatic logic [1:0] exp_state(input int n);
    if (m_run == 0) return 2'd0;
    if (m_run <= n) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [DQ_W-1:0] exp_oe(input int n);
    return (exp_state(n) == 2'd2) ? m_oe_s : '0;
  endfunction

  function automatic logic [DQ_W-1:0] exp_ie(input int n);
    case (exp_state(n))
      2'd2:    return ~m_oe_s;
      2'd1:    return '0;
      default: return '1;
    endcase
  endfunction

  task automatic idle(input int cycles);
    spi_dq_oe = '0;
    repeat (cycles) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; spi_dq_oe = '1; spi_cs = '0; spi_dq_o = '1; spi_sck = 1'b1;
    pins_dq_ival = '1; cfg_loopback = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({pins_cs_oval, pins_dq_oe, pins_dq_ie, dir_state, spi_dq_i} !== {4'hF, 4'h0, 4'hF, 2'd0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_main: cs_oval=%h oe=%h ie=%h st=%0d dq_i=%h want F 0 F 0 0",
               pins_cs_oval, pins_dq_oe, pins_dq_ie, dir_state, spi_dq_i);
    end
    n_cmp++;
    if ({pins_sck_oval, pins_dq_oval, pins_sck_oe, pins_cs_oe, pins_dq_pue} !== {1'b0, 4'h0, 1'b1, 4'hF, 4'hF}) begin
      n_fail++;
      $display("FAIL reset_const: sck=%b dq_oval=%h sck_oe=%b cs_oe=%h pue=%h want 0 0 1 F F",
               pins_sck_oval, pins_dq_oval, pins_sck_oe, pins_cs_oe, pins_dq_pue);
    end
    n_cmp++;
    if ({pins_dq_oe_z, dir_state_z} !== {4'h0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_turn0: oe=%h st=%0d want 0 0", pins_dq_oe_z, dir_state_z);
    end
    spi_dq_oe = '0; spi_cs = '1; spi_dq_o = '0; spi_sck = 1'b0; pins_dq_ival = '0;
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_turnaround();
    spi_dq_oe = 4'h1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({dir_state, pins_dq_oe, pins_dq_ie} !==
          {(k <= 3) ? 2'd1 : 2'd2, (k >= 4) ? 4'h1 : 4'h0, (k >= 4) ? 4'hE : 4'h0}) begin
        n_fail++;
        $display("FAIL turnaround_k%0d: st=%0d oe=%h ie=%h", k, dir_state, pins_dq_oe, pins_dq_ie);
      end
      n_cmp++;
      if ({dir_state_z, pins_dq_oe_z, pins_dq_ie_z} !== {2'd2, 4'h1, 4'hE}) begin
        n_fail++;
        $display("FAIL turnaround0_k%0d: st=%0d oe=%h ie=%h want 2 1 E", k, dir_state_z, pins_dq_oe_z, pins_dq_ie_z);
      end
    end
  endtask

  task automatic test_per_bit();
    spi_dq_oe = 4'hC;
    @(negedge clk);
    n_cmp++;
    if ({dir_state, pins_dq_oe, pins_dq_ie} !== {2'd2, 4'hC, 4'h3}) begin
      n_fail++;
      $display("FAIL per_bit_C: st=%0d oe=%h ie=%h want 2 C 3", dir_state, pins_dq_oe, pins_dq_ie);
    end
    spi_dq_oe = 4'h5;
    @(negedge clk);
    n_cmp++;
    if ({dir_state, pins_dq_oe, pins_dq_ie} !== {2'd2, 4'h5, 4'hA}) begin
      n_fail++;
      $display("FAIL per_bit_5: st=%0d oe=%h ie=%h want 2 5 A", dir_state, pins_dq_oe, pins_dq_ie);
    end
  endtask

  task automatic test_release();
    spi_dq_oe = 4'h0;
    @(negedge clk);
    n_cmp++;
    if ({dir_state, pins_dq_oe, pins_dq_ie} !== {2'd0, 4'h0, 4'hF}) begin
      n_fail++;
      $display("FAIL release: st=%0d oe=%h ie=%h want 0 0 F", dir_state, pins_dq_oe, pins_dq_ie);
    end
    spi_dq_oe = 4'h3;
    @(negedge clk);
    n_cmp++;
    if ({dir_state_z, pins_dq_oe_z, pins_dq_ie_z} !== {2'd2, 4'h3, 4'hC}) begin
      n_fail++;
      $display("FAIL rise_turn0: st=%0d oe=%h ie=%h want 2 3 C", dir_state_z, pins_dq_oe_z, pins_dq_ie_z);
    end
    n_cmp++;
    if ({dir_state, pins_dq_oe} !== {2'd1, 4'h0}) begin
      n_fail++;
      $display("FAIL rise_turn3: st=%0d oe=%h want 1 0", dir_state, pins_dq_oe);
    end
    idle(2);
  endtask

  task automatic test_abort();
    idle(2);
    spi_dq_oe = 4'hF;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if ({dir_state, pins_dq_oe} !== {2'd1, 4'h0}) begin
        n_fail++;
        $display("FAIL abort_turn: st=%0d oe=%h want 1 0", dir_state, pins_dq_oe);
      end
    end
    spi_dq_oe = 4'h0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({dir_state, pins_dq_oe, pins_dq_ie} !== {2'd0, 4'h0, 4'hF}) begin
        n_fail++;
        $display("FAIL abort_in_k%0d: st=%0d oe=%h ie=%h want 0 0 F", k, dir_state, pins_dq_oe, pins_dq_ie);
      end
    end
  endtask

  task automatic test_sync();
    cfg_loopback = 1'b0; pins_dq_ival = 4'h0; spi_dq_o = 4'h0;
    idle(3);
    pins_dq_ival = 4'hA;
    @(negedge clk);
    n_cmp++;
    if (spi_dq_i !== 4'h0) begin
      n_fail++;
      $display("FAIL sync_early: got %h want 0", spi_dq_i);
    end
    @(negedge clk);
    n_cmp++;
    if ({spi_dq_i, spi_dq_i_z} !== {4'hA, 4'hA}) begin
      n_fail++;
      $display("FAIL sync_lat: got %h/%h want A/A", spi_dq_i, spi_dq_i_z);
    end
    spi_dq_oe = 4'hF;
    repeat (6) @(negedge clk);
    cfg_loopback = 1'b1; spi_dq_o = 4'h5;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (spi_dq_i !== 4'h0) begin
      n_fail++;
      $display("FAIL loop_early: got %h want 0", spi_dq_i);
    end
    @(negedge clk);
    n_cmp++;
    if ({spi_dq_i, dir_state, pins_dq_oval} !== {4'h5, 2'd2, 4'h5}) begin
      n_fail++;
      $display("FAIL loop_lat: dq_i=%h st=%0d oval=%h want 5 2 5", spi_dq_i, dir_state, pins_dq_oval);
    end
    cfg_loopback = 1'b0;
  endtask

  task automatic test_reset_mid_out();
    spi_dq_oe = 4'hF;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (pins_dq_oe !== 4'hF) begin
      n_fail++;
      $display("FAIL pre_rst_out: oe=%h want F", pins_dq_oe);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pins_dq_oe, dir_state, pins_dq_ie, pins_dq_oe_z, dir_state_z} !== {4'h0, 2'd0, 4'hF, 4'h0, 2'd0}) begin
      n_fail++;
      $display("FAIL rst_async: oe=%h st=%0d ie=%h oe0=%h st0=%0d want 0 0 F 0 0",
               pins_dq_oe, dir_state, pins_dq_ie, pins_dq_oe_z, dir_state_z);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({dir_state, pins_dq_oe, dir_state_z} !== {2'd1, 4'h0, 2'd2}) begin
      n_fail++;
      $display("FAIL post_rst: st=%0d oe=%h st0=%0d want 1 0 2", dir_state, pins_dq_oe, dir_state_z);
    end
    idle(2);
  endtask

  task automatic test_random();
    logic on;
    on = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({dir_state, pins_dq_oe, pins_dq_ie} !== {exp_state(TURN), exp_oe(TURN), exp_ie(TURN)}) begin
        n_fail++;
        $display("FAIL rand_dir c%0d: st=%0d oe=%h ie=%h want %0d %h %h", c, dir_state, pins_dq_oe,
                 pins_dq_ie, exp_state(TURN), exp_oe(TURN), exp_ie(TURN));
      end
      n_cmp++;
      if ({dir_state_z, pins_dq_oe_z, pins_dq_ie_z} !== {exp_state(0), exp_oe(0), exp_ie(0)}) begin
        n_fail++;
        $display("FAIL rand_dir0 c%0d: st=%0d oe=%h ie=%h want %0d %h %h", c, dir_state_z, pins_dq_oe_z,
                 pins_dq_ie_z, exp_state(0), exp_oe(0), exp_ie(0));
      end
      n_cmp++;
      if ({pins_sck_oval, pins_dq_oval, pins_cs_oval, spi_dq_i, spi_dq_i_z} !==
          {m_sck, m_dq_oval, m_cs, m_sh[SYNC-1], m_sh[SYNC-1]}) begin
        n_fail++;
        $display("FAIL rand_data c%0d: sck=%b oval=%h cs=%h dq_i=%h/%h want %b %h %h %h", c, pins_sck_oval,
                 pins_dq_oval, pins_cs_oval, spi_dq_i, spi_dq_i_z, m_sck, m_dq_oval, m_cs, m_sh[SYNC-1]);
      end
      n_cmp++;
      if ((dir_state != 2'd2) && (pins_dq_oe != 4'h0)) begin
        n_fail++;
        $display("FAIL rand_guard c%0d: st=%0d oe=%h want oe 0", c, dir_state, pins_dq_oe);
      end
      if ($urandom_range(0, 7) == 0) on = ~on;
      spi_dq_oe = on ? 4'($urandom_range(1, 15)) : 4'h0;
      spi_dq_o = 4'($urandom);
      spi_cs = 4'($urandom);
      spi_sck = 1'($urandom);
      pins_dq_ival = 4'($urandom);
      if ($urandom_range(0, 15) == 0) cfg_loopback = ~cfg_loopback;
    end
  endtask

  initial begin
    test_reset();
    test_turnaround();
    test_per_bit();
    test_release();
    test_abort();
    test_sync();
    test_reset_mid_out();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
